// File: rtl/gpio_edge_intr.sv
// GPIO edge/level interrupt block.
// Takes already-debounced channel values and detects rising edges, falling
// edges and high/low levels per channel. Enabled events set a sticky
// interrupt state bit, which software clears with a write-1-to-clear mask
// and can force with a write-1-to-set test mask. A set arriving in the same
// cycle as a clear of the same bit wins. Channels never interact.
module gpio_edge_intr #(
    parameter int NumIo = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NumIo-1:0] data_i,
    input  logic [NumIo-1:0] en_rise_i,
    input  logic [NumIo-1:0] en_fall_i,
    input  logic [NumIo-1:0] en_lvlhi_i,
    input  logic [NumIo-1:0] en_lvllo_i,
    input  logic [NumIo-1:0] intr_enable_i,
    input  logic             clr_we_i,
    input  logic [NumIo-1:0] clr_i,
    input  logic             test_we_i,
    input  logic [NumIo-1:0] test_i,
    output logic [NumIo-1:0] data_q_o,
    output logic [NumIo-1:0] intr_state_o,
    output logic [NumIo-1:0] intr_o,
    output logic [NumIo-1:0] event_o
);

    logic [NumIo-1:0] data_q;
    logic             valid;
    logic [NumIo-1:0] event_q;
    logic [NumIo-1:0] intr_state;

    logic [NumIo-1:0] valid_mask;
    logic [NumIo-1:0] rise;
    logic [NumIo-1:0] fall;
    logic [NumIo-1:0] lvlhi;
    logic [NumIo-1:0] lvllo;
    logic [NumIo-1:0] hw_evt;
    logic [NumIo-1:0] clr_mask;
    logic [NumIo-1:0] set_mask;
    logic [NumIo-1:0] intr_state_next;

    // Event detection. Edges need a trustworthy previous sample, so they are
    // gated by valid; levels look only at the current sample and are live from
    // the first cycle after reset.
    always_comb begin
        valid_mask = {NumIo{valid}};
        rise       = valid_mask & data_i & ~data_q;
        fall       = valid_mask & ~data_i & data_q;
        lvlhi      = data_i;
        lvllo      = ~data_i;
        hw_evt     = (rise & en_rise_i) | (fall & en_fall_i)
                   | (lvlhi & en_lvlhi_i) | (lvllo & en_lvllo_i);
    end

    // Next sticky state: clear first, then OR in sets so a set always wins.
    always_comb begin
        clr_mask        = clr_we_i  ? clr_i  : '0;
        set_mask        = test_we_i ? test_i : '0;
        intr_state_next = (intr_state & ~clr_mask) | hw_evt | set_mask;
    end

    // Sample register, valid flag, event pulse register and sticky state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q     <= '0;
            valid      <= 1'b0;
            event_q    <= '0;
            intr_state <= '0;
        end else begin
            data_q     <= data_i;
            valid      <= 1'b1;
            event_q    <= hw_evt;
            intr_state <= intr_state_next;
        end
    end

    // Outputs come straight from registers; the mask applies with no latency.
    always_comb begin
        data_q_o     = data_q;
        event_o      = event_q;
        intr_state_o = intr_state;
        intr_o       = intr_state & intr_enable_i;
    end

endmodule

// File: tb/tb_gpio_edge_intr.sv
// Self-checking bench for gpio_edge_intr (NumIo = 8).
module tb_gpio_edge_intr;

    localparam int N = 8;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic [N-1:0] data_i, en_rise_i, en_fall_i, en_lvlhi_i, en_lvllo_i;
    logic [N-1:0] intr_enable_i, clr_i, test_i;
    logic         clr_we_i, test_we_i;
    logic [N-1:0] data_q_o, intr_state_o, intr_o, event_o;

    gpio_edge_intr #(.NumIo(N)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .data_i        (data_i),
        .en_rise_i     (en_rise_i),
        .en_fall_i     (en_fall_i),
        .en_lvlhi_i    (en_lvlhi_i),
        .en_lvllo_i    (en_lvllo_i),
        .intr_enable_i (intr_enable_i),
        .clr_we_i      (clr_we_i),
        .clr_i         (clr_i),
        .test_we_i     (test_we_i),
        .test_i        (test_i),
        .data_q_o      (data_q_o),
        .intr_state_o  (intr_state_o),
        .intr_o        (intr_o),
        .event_o       (event_o)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model state ----------------
    logic [N-1:0] m_dq;
    logic         m_valid;
    logic [N-1:0] m_state;

    // Scoreboard entry: {event, intr_state, data_q}
    logic [3*N-1:0] exp_q[$];

    task automatic model_reset();
        m_dq    = '0;
        m_valid = 1'b0;
        m_state = '0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        en_rise_i  = '0;
        en_fall_i  = '0;
        en_lvlhi_i = '0;
        en_lvllo_i = '0;
        clr_we_i   = 1'b0;
        clr_i      = '0;
        test_we_i  = 1'b0;
        test_i     = '0;
    endtask

    // Drive one clock with the current inputs: push the expectation derived
    // from the behavioural equations, advance, then pop and compare.
    task automatic cycle();
        logic [N-1:0]   rise, fall, hw, nxt;
        logic [3*N-1:0] e;
        rise = (m_valid ? data_i & ~m_dq : '0);
        fall = (m_valid ? ~data_i & m_dq : '0);
        hw   = (rise & en_rise_i) | (fall & en_fall_i) |
               (data_i & en_lvlhi_i) | (~data_i & en_lvllo_i);
        nxt  = (m_state & ~(clr_we_i ? clr_i : '0)) | hw | (test_we_i ? test_i : '0);
        exp_q.push_back({hw, nxt, data_i});
        m_dq    = data_i;
        m_valid = 1'b1;
        m_state = nxt;
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (event_o !== e[3*N-1:2*N]) begin
            failures++;
            $display("FAIL sb_event: got %h expected %h", event_o, e[3*N-1:2*N]);
        end
        checks++;
        if (intr_state_o !== e[2*N-1:N]) begin
            failures++;
            $display("FAIL sb_state: got %h expected %h", intr_state_o, e[2*N-1:N]);
        end
        checks++;
        if (data_q_o !== e[N-1:0]) begin
            failures++;
            $display("FAIL sb_data_q: got %h expected %h", data_q_o, e[N-1:0]);
        end
        checks++;
        if (intr_o !== (e[2*N-1:N] & intr_enable_i)) begin
            failures++;
            $display("FAIL sb_intr: got %h expected %h", intr_o, e[2*N-1:N] & intr_enable_i);
        end
    endtask

    task automatic clear_all();
        idle_inputs();
        clr_we_i = 1'b1;
        clr_i    = '1;
        cycle();
        idle_inputs();
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        idle_inputs();
        intr_enable_i = '1;
        data_i        = 8'h01;
        en_rise_i     = 8'hFF;
        rst_ni        = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({data_q_o, event_o, intr_state_o, intr_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h %h %h %h expected all 0",
                     data_q_o, event_o, intr_state_o, intr_o);
        end
        model_reset();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (event_o !== 8'h00 || intr_state_o !== 8'h00) begin
                failures++;
                $display("FAIL reset_no_spurious_edge: got evt=%h state=%h expected 00 00",
                         event_o, intr_state_o);
            end
        end
        idle_inputs();
    endtask

    task automatic test_rise();
        clear_all();
        data_i        = 8'h00;
        intr_enable_i = 8'h08;
        en_rise_i     = 8'h08;
        cycle();
        data_i = 8'h08;
        cycle();
        checks++;
        if (event_o !== 8'h08 || intr_state_o !== 8'h08 || intr_o !== 8'h08) begin
            failures++;
            $display("FAIL rise_ch3: got evt=%h state=%h intr=%h expected 08 08 08",
                     event_o, intr_state_o, intr_o);
        end
        cycle();
        checks++;
        if (event_o !== 8'h00 || intr_state_o !== 8'h08) begin
            failures++;
            $display("FAIL rise_pulse_width: got evt=%h state=%h expected 00 08",
                     event_o, intr_state_o);
        end
        // Disabling the enable must not clear the sticky bit.
        en_rise_i = 8'h00;
        cycle();
        checks++;
        if (intr_state_o !== 8'h08) begin
            failures++;
            $display("FAIL enable_change_keeps_state: got %h expected 08", intr_state_o);
        end
        idle_inputs();
    endtask

    task automatic test_fall_set_wins();
        clear_all();
        en_fall_i = 8'h01;
        data_i    = 8'h01;
        cycle();
        data_i   = 8'h00;
        clr_we_i = 1'b1;
        clr_i    = 8'h01;
        cycle();
        checks++;
        if (intr_state_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL fall_set_wins: got %b expected 1", intr_state_o[0]);
        end
        idle_inputs();
    endtask

    task automatic test_clear_partial();
        clear_all();
        test_we_i = 1'b1;
        test_i    = 8'hFF;
        cycle();
        idle_inputs();
        clr_we_i = 1'b1;
        clr_i    = 8'h0F;
        cycle();
        checks++;
        if (intr_state_o !== 8'hF0) begin
            failures++;
            $display("FAIL clear_low_nibble: got %h expected f0", intr_state_o);
        end
        // Strobe low: clr_i must be ignored.
        clr_we_i = 1'b0;
        clr_i    = 8'hFF;
        cycle();
        checks++;
        if (intr_state_o !== 8'hF0) begin
            failures++;
            $display("FAIL clr_without_strobe: got %h expected f0", intr_state_o);
        end
        idle_inputs();
    endtask

    task automatic test_level_high();
        data_i = 8'h00;
        clear_all();
        en_lvlhi_i = 8'h20;
        data_i     = 8'h20;
        clr_we_i   = 1'b1;
        clr_i      = 8'h20;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (event_o[5] !== 1'b1 || intr_state_o[5] !== 1'b1) begin
                failures++;
                $display("FAIL level_high_cycle%0d: got evt5=%b state5=%b expected 1 1",
                         i, event_o[5], intr_state_o[5]);
            end
        end
        data_i = 8'h00;
        cycle();
        checks++;
        if (event_o[5] !== 1'b0 || intr_state_o[5] !== 1'b0) begin
            failures++;
            $display("FAIL level_high_end: got evt5=%b state5=%b expected 0 0",
                     event_o[5], intr_state_o[5]);
        end
        idle_inputs();
    endtask

    task automatic test_sw_set();
        clear_all();
        intr_enable_i = 8'h01;
        test_we_i     = 1'b1;
        test_i        = 8'h81;
        cycle();
        checks++;
        if (intr_state_o !== 8'h81 || intr_o !== 8'h01 || event_o !== 8'h00) begin
            failures++;
            $display("FAIL test_set: got state=%h intr=%h evt=%h expected 81 01 00",
                     intr_state_o, intr_o, event_o);
        end
        idle_inputs();
        // Mask change must show on intr_o without a clock.
        #1 intr_enable_i = 8'hFF;
        #1;
        checks++;
        if (intr_o !== 8'h81) begin
            failures++;
            $display("FAIL mask_no_latency: got %h expected 81", intr_o);
        end
        test_i = 8'hFF;  // strobe low: ignored
        cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            data_i        = N'($urandom_range(0, 255));
            en_rise_i     = N'($urandom_range(0, 255));
            en_fall_i     = N'($urandom_range(0, 255));
            en_lvlhi_i    = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255)) : '0;
            en_lvllo_i    = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255)) : '0;
            intr_enable_i = N'($urandom_range(0, 255));
            clr_we_i      = 1'($urandom_range(0, 1));
            clr_i         = N'($urandom_range(0, 255));
            test_we_i     = ($urandom_range(0, 5) == 0);
            test_i        = N'($urandom_range(0, 255));
            cycle();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        test_we_i = 1'b1;
        test_i    = 8'h5A;
        data_i    = 8'hC3;
        cycle();
        idle_inputs();
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({data_q_o, event_o, intr_state_o, intr_o} !== '0) begin
            failures++;
            $display("FAIL async_reset: got %h %h %h %h expected all 0",
                     data_q_o, event_o, intr_state_o, intr_o);
        end
        model_reset();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        en_rise_i = 8'hFF;
        en_fall_i = 8'hFF;
        data_i    = 8'h3C;
        cycle();
        checks++;
        if (event_o !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_edge_suppressed: got %h expected 00", event_o);
        end
        data_i = 8'h0F;
        cycle();
        checks++;
        if (event_o !== 8'h33) begin
            failures++;
            $display("FAIL post_reset_edges_resume: got %h expected 33", event_o);
        end
        idle_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_ni        = 1'b0;
        data_i        = '0;
        intr_enable_i = '0;
        idle_inputs();
        model_reset();
        test_reset();
        test_rise();
        test_fall_set_wins();
        test_clear_partial();
        test_level_high();
        test_sw_set();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
